uart_mul_frontend: RTL and testbench
====================================

# uart_mul_frontend

Serial front end for the 8-bit multiplier. It receives operand A, then operand B, as two 8N1 UART bytes and drives them onto the multiplier inputs. It then captures the 16-bit product and transmits it back as two UART bytes, low byte first. It sits between the chip pins (`rx_i`/`tx_o`) and the combinational multiplier core, whose product it consumes.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Must be ≥ 4.
- `clk`  input  1  single clock; all state is on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rx_i`  input  1  UART receive line, idle high, asynchronous to `clk`.
- `tx_o`  output  1  UART transmit line, idle high. Reset value 1.
- `mul_a_o`  output  8  operand A to the multiplier. Reset value 0x00.
- `mul_b_o`  output  8  operand B to the multiplier. Reset value 0x00.
- `prod_i`  input  16  product from the combinational multiplier; must equal `mul_a_o * mul_b_o`.
- `busy_o`  output  1  high from B accepted until the high-byte stop bit ends. Reset value 0.
- `frame_err_o`  output  1  one-cycle pulse on a bad received frame. Reset value 0.

## Operation
- **RX path**
  - `rx_i` passes through a 2-flop synchronizer before any use.
  - IDLE→START on a synchronized falling edge.
  - START: sample at CLKS_PER_BIT/2 (integer division). If the line is high, it is a false start and the path returns to IDLE with no strobe.
  - DATA: 8 samples, each CLKS_PER_BIT apart, LSB first.
  - STOP: sample one CLKS_PER_BIT later.
    - Stop = 1 → internal `rx_valid` strobe for one cycle with the byte.
    - Stop = 0 → `frame_err_o` pulses and the byte is discarded.
  - RX returns to IDLE in the cycle after the stop sample. It then waits for `rx_i` high before it can detect a new falling edge.
- **Command FSM**: states WAIT_A, WAIT_B, CAPTURE, SEND_LO, SEND_HI.
  - WAIT_A: on `rx_valid`, load `mul_a_o` and go to WAIT_B.
  - WAIT_B: on `rx_valid`, load `mul_b_o`, set `busy_o`, and go to CAPTURE.
  - CAPTURE: one cycle; latch `prod_i` into a 16-bit result register and go to SEND_LO.
  - SEND_LO: transmit result[7:0]; when its stop bit ends, go to SEND_HI.
  - SEND_HI: transmit result[15:8]; when its stop bit ends, clear `busy_o` and go to WAIT_A.
  - A frame error in any state returns the FSM to WAIT_A, except in SEND_LO and SEND_HI, where it is ignored.
  - Bytes received during CAPTURE, SEND_LO and SEND_HI are dropped silently. The RX path keeps running (full duplex).
  - `mul_a_o` and `mul_b_o` hold their values until they are next overwritten.
- **TX path**: start bit (0), 8 data bits LSB first, stop bit (1), each exactly CLKS_PER_BIT cycles. `tx_o` is registered.
- **Reset**: asserting `rst` at any time, including mid-frame or mid-transmit, immediately forces every output to its reset value. The FSM goes to WAIT_A, RX to IDLE, and the synchronizer flops to 1.

## Timing
- **Latency from B to A-side inputs**: `mul_b_o` updates on the cycle after the stop-bit sample of byte B.
  - CAPTURE is the following cycle.
  - The `tx_o` start bit begins on the cycle after CAPTURE.
- **Byte spacing**: the SEND_HI start bit begins on the cycle immediately after the SEND_LO stop bit's last cycle, with no idle gap. One result takes 2×10×CLKS_PER_BIT cycles on the line (22× with parity).
- **Synchronizer delay**: RX detection lags the pin by 2 cycles. Sample points are measured from the synchronized edge.
- `frame_err_o` and the internal `rx_valid` are never asserted in the same cycle.

## Configuration
- `UART_MUL_PARITY_EN`
  - **Defined**: both directions use 8E1. One even-parity bit follows the data bit, sampled and driven for CLKS_PER_BIT cycles. On RX, a parity mismatch is handled exactly like a stop-bit error: `frame_err_o` pulses and the byte is discarded. On TX, the parity bit equals the XOR of the 8 data bits.
  - **Undefined**: 8N1 only, with no parity logic.

## Test plan
- CLKS_PER_BIT=8; the bench models the multiplier as `prod_i = mul_a_o * mul_b_o`.
- Send 0x0C then 0x0B → `mul_a_o`=0x0C, `mul_b_o`=0x0B; `tx_o` sends 0x84 then 0x00 back-to-back; `busy_o` drops after the second stop bit.
- Send 0xFF then 0xFF → `tx_o` sends 0x01 then 0xFE.
- Send 0x05, then a frame with stop bit forced to 0, then 0x03, 0x04 → one `frame_err_o` pulse; the result transmitted is 0x0C, 0x00 (A=0x03, B=0x04).
- Pulse `rx_i` low for 3 cycles while idle → no byte and no `frame_err_o`; the FSM stays in WAIT_A.
- Send 0x02, 0x03; during SEND_LO inject byte 0x55 → the result is 0x06, 0x00 and 0x55 is ignored. Then assert `rst` mid SEND_HI → `tx_o`=1, `busy_o`=0, operands 0x00; the next pair 0x02, 0x02 yields 0x04, 0x00.
- With `UART_MUL_PARITY_EN`: send 0x03 with parity 1 (wrong) → `frame_err_o` pulses. Then send 0x03, 0x07 with correct parity → TX 0x15 with parity 1, then 0x00 with parity 0.

Source files
------------

// File: rtl/uart_mul_frontend.sv
`timescale 1ns/1ps
// uart_mul_frontend
//
// Serial front end for an 8-bit combinational multiplier. Two UART bytes arrive
// on rx_i (operand A, then operand B) and are driven onto mul_a_o / mul_b_o.
// One cycle later the 16-bit product on prod_i is captured and sent back on
// tx_o as two UART bytes, low byte first, with no idle gap between them.
//
// Optional feature: define UART_MUL_PARITY_EN to switch both directions from
// 8N1 to 8E1. An RX parity mismatch is treated like a bad stop bit.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   rx_i         UART receive line, idle high, asynchronous to clk
//   tx_o         UART transmit line, idle high (registered)
//   mul_a_o      operand A to the multiplier
//   mul_b_o      operand B to the multiplier
//   prod_i       product from the multiplier (mul_a_o * mul_b_o)
//   busy_o       high from B accepted until the high-byte stop bit ends
//   frame_err_o  one-cycle pulse on a bad received frame
module uart_mul_frontend #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        tx_o,
  output logic [7:0]  mul_a_o,
  output logic [7:0]  mul_b_o,
  input  logic [15:0] prod_i,
  output logic        busy_o,
  output logic        frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    CmdWaitA,
    CmdWaitB,
    CmdCapture,
    CmdSendLo,
    CmdSendHi
  } cmd_state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  rx_state_e       rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  // Cleared after each frame; a new start is only accepted once the line has
  // been seen high again, so a stuck-low line after a bad stop bit is ignored.
  logic            rx_armed_q;
  logic            rx_stop_hit;
  logic            rx_bad;
  logic            rx_valid;
  logic            rx_ferr;

`ifdef UART_MUL_PARITY_EN
  logic rx_par_err_q;
  assign rx_bad = !rx_s || rx_par_err_q;
`else
  assign rx_bad = !rx_s;
`endif

  assign rx_stop_hit = (rx_state_q == RxStop) && (rx_cnt_q == BitLast);
  assign rx_valid    = rx_stop_hit && !rx_bad;
  assign rx_ferr     = rx_stop_hit && rx_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RxIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_armed_q   <= 1'b1;
      frame_err_o  <= 1'b0;
`ifdef UART_MUL_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      frame_err_o <= rx_ferr;
      case (rx_state_q)
        RxIdle: begin
          rx_cnt_q <= '0;
          if (!rx_armed_q) begin
            rx_armed_q <= rx_s;
          end else if (!rx_s) begin
            rx_armed_q <= 1'b0;
            rx_state_q <= RxStart;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q <= '0;
            rx_bit_q <= 3'd0;
            // Line back high at mid start bit: glitch, not a frame.
            rx_state_q <= rx_s ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntOne;
          end
        end
        RxData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
`ifdef UART_MUL_PARITY_EN
              rx_state_q <= RxParity;
`else
              rx_state_q <= RxStop;
`endif
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CntOne;
          end
        end
`ifdef UART_MUL_PARITY_EN
        RxParity: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q     <= '0;
            rx_par_err_q <= rx_s ^ (^rx_shift_q);
            rx_state_q   <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntOne;
          end
        end
`endif
        RxStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntOne;
          end
        end
        default: begin
          rx_cnt_q   <= '0;
          rx_state_q <= RxIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  tx_state_e       tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_shift_q;
  logic            tx_done;
  logic            tx_load;
  logic [7:0]      tx_byte;

`ifdef UART_MUL_PARITY_EN
  logic tx_par_q;
`endif

  // Last cycle of the stop bit; a load in this cycle starts the next byte
  // without any idle gap.
  assign tx_done = (tx_state_q == TxStop) && (tx_cnt_q == BitLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_o       <= 1'b1;
`ifdef UART_MUL_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else if (tx_load) begin
      tx_state_q <= TxStart;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= tx_byte;
      tx_o       <= 1'b0;
`ifdef UART_MUL_PARITY_EN
      tx_par_q   <= ^tx_byte;
`endif
    end else begin
      case (tx_state_q)
        TxIdle: begin
          tx_cnt_q <= '0;
          tx_o     <= 1'b1;
        end
        TxStart: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TxData;
            tx_o       <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + CntOne;
          end
        end
        TxData: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
`ifdef UART_MUL_PARITY_EN
              tx_state_q <= TxParity;
              tx_o       <= tx_par_q;
`else
              tx_state_q <= TxStop;
              tx_o       <= 1'b1;
`endif
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_o       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CntOne;
          end
        end
`ifdef UART_MUL_PARITY_EN
        TxParity: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TxStop;
            tx_o       <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + CntOne;
          end
        end
`endif
        TxStop: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TxIdle;
          end else begin
            tx_cnt_q <= tx_cnt_q + CntOne;
          end
          tx_o <= 1'b1;
        end
        default: begin
          tx_cnt_q   <= '0;
          tx_state_q <= TxIdle;
          tx_o       <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  cmd_state_e cmd_state_q;
  // The low product byte is latched straight into the TX shifter at capture,
  // so only the high byte needs holding here until SEND_HI.
  logic [7:0] result_hi_q;

  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    case (cmd_state_q)
      CmdCapture: begin
        if (!rx_ferr) begin
          tx_load = 1'b1;
          tx_byte = prod_i[7:0];
        end
      end
      CmdSendLo: begin
        if (tx_done) begin
          tx_load = 1'b1;
          tx_byte = result_hi_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_state_q <= CmdWaitA;
      mul_a_o     <= 8'h00;
      mul_b_o     <= 8'h00;
      busy_o      <= 1'b0;
      result_hi_q <= 8'h00;
    end else begin
      case (cmd_state_q)
        CmdWaitA: begin
          if (rx_valid) begin
            mul_a_o     <= rx_shift_q;
            cmd_state_q <= CmdWaitB;
          end
        end
        CmdWaitB: begin
          if (rx_valid) begin
            mul_b_o     <= rx_shift_q;
            busy_o      <= 1'b1;
            cmd_state_q <= CmdCapture;
          end else if (rx_ferr) begin
            cmd_state_q <= CmdWaitA;
          end
        end
        CmdCapture: begin
          if (rx_ferr) begin
            busy_o      <= 1'b0;
            cmd_state_q <= CmdWaitA;
          end else begin
            result_hi_q <= prod_i[15:8];
            cmd_state_q <= CmdSendLo;
          end
        end
        CmdSendLo: begin
          if (tx_done) begin
            cmd_state_q <= CmdSendHi;
          end
        end
        CmdSendHi: begin
          if (tx_done) begin
            busy_o      <= 1'b0;
            cmd_state_q <= CmdWaitA;
          end
        end
        default: begin
          busy_o      <= 1'b0;
          cmd_state_q <= CmdWaitA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mul_frontend.sv
`timescale 1ns/1ps
// Directed bench for uart_mul_frontend with CLKS_PER_BIT = 8. The multiplier
// is modelled combinationally; a line monitor decodes every byte on tx.
module tb_uart_mul_frontend;

  localparam int unsigned Cpb = 8;
`ifdef UART_MUL_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] prod;
  logic        busy;
  logic        ferr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ferr_cnt = 0;
  int f0;

  logic [7:0] tx_q[$];
  logic       tx_stop_q[$];
  logic       tx_par_q[$];
  int         tx_t[$];

`ifdef UART_MUL_PARITY_EN
  logic bad_par = 1'b0;
`endif

  uart_mul_frontend #(.CLKS_PER_BIT(Cpb)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx),
    .tx_o        (tx),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .prod_i      (prod),
    .busy_o      (busy),
    .frame_err_o (ferr)
  );

  assign prod = {8'h00, mul_a} * {8'h00, mul_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ferr === 1'b1) ferr_cnt <= ferr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drives one frame starting on a falling clock edge.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    @(negedge clk) rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (Cpb) @(negedge clk);
    end
`ifdef UART_MUL_PARITY_EN
    rx = (^d) ^ bad_par;
    repeat (Cpb) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (Cpb) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("tx_byte_count", tx_q.size(), n);
  endtask

  task automatic clear_tx();
    tx_q.delete();
    tx_stop_q.delete();
    tx_par_q.delete();
    tx_t.delete();
  endtask

  // Line monitor: samples each bit at its midpoint.
  initial begin : tx_mon
    logic [7:0] b;
    int t;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        t = cyc;
        repeat (Cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_MUL_PARITY_EN
        repeat (Cpb) @(negedge clk);
        tx_par_q.push_back(tx);
`endif
        repeat (Cpb) @(negedge clk);
        tx_stop_q.push_back(tx);
        tx_q.push_back(b);
        tx_t.push_back(t);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_mul_a", mul_a, 8'h00);
    check("rst_mul_b", mul_b, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_ferr", ferr, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0x0C * 0x0B = 0x0084
    send_byte(8'h0C, 1'b1);
    check("t1_mul_a", mul_a, 8'h0C);
    check("t1_busy_after_a", busy, 0);
    send_byte(8'h0B, 1'b1);
    check("t1_mul_b", mul_b, 8'h0B);
    check("t1_busy_after_b", busy, 1);
    check("t1_tx_started", tx, 0);
    wait_tx(2, 400);
    check("t1_lo", tx_q[0], 8'h84);
    check("t1_hi", tx_q[1], 8'h00);
    check("t1_gap", tx_t[1] - tx_t[0], FrameBits * Cpb);
    check("t1_stop_lo", tx_stop_q[0], 1);
    check("t1_stop_hi", tx_stop_q[1], 1);
`ifdef UART_MUL_PARITY_EN
    check("t1_par_lo", tx_par_q[0], 0);
    check("t1_par_hi", tx_par_q[1], 0);
`endif
    check("t1_busy_in_stop", busy, 1);
    repeat (5) @(negedge clk);
    check("t1_busy_done", busy, 0);
    check("t1_tx_idle", tx, 1);
    clear_tx();

    // Short low glitch while idle: no byte, no frame error.
    f0 = ferr_cnt;
    @(negedge clk) rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_mul_a", mul_a, 8'h0C);
    check("glitch_tx_none", tx_q.size(), 0);

    // 0xFF * 0xFF = 0xFE01; first byte must land in A.
    send_byte(8'hFF, 1'b1);
    check("t2_mul_a", mul_a, 8'hFF);
    check("t2_mul_b_held", mul_b, 8'h0B);
    send_byte(8'hFF, 1'b1);
    wait_tx(2, 400);
    check("t2_lo", tx_q[0], 8'h01);
    check("t2_hi", tx_q[1], 8'hFE);
    repeat (10) @(negedge clk);
    clear_tx();

    // Bad stop bit between A and B restarts the operand sequence.
    f0 = ferr_cnt;
    send_byte(8'h05, 1'b1);
    check("t3_mul_a_05", mul_a, 8'h05);
    send_byte(8'h5A, 1'b0);
    repeat (30) @(negedge clk);
    check("t3_ferr_pulse", ferr_cnt - f0, 1);
    check("t3_mul_b_held", mul_b, 8'hFF);
    check("t3_busy", busy, 0);
    send_byte(8'h03, 1'b1);
    check("t3_mul_a_03", mul_a, 8'h03);
    send_byte(8'h04, 1'b1);
    wait_tx(2, 400);
    check("t3_lo", tx_q[0], 8'h0C);
    check("t3_hi", tx_q[1], 8'h00);
    check("t3_ferr_total", ferr_cnt - f0, 1);
    repeat (10) @(negedge clk);
    clear_tx();

    // Byte arriving during SEND_LO is dropped.
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_tx(2, 400);
    check("t4_lo", tx_q[0], 8'h06);
    check("t4_hi", tx_q[1], 8'h00);
    check("t4_mul_a", mul_a, 8'h02);
    check("t4_mul_b", mul_b, 8'h03);
    repeat (10) @(negedge clk);
    clear_tx();

    // Reset in the middle of SEND_HI.
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    wait_tx(1, 300);
    repeat (20) @(negedge clk);
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_tx", tx, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_mul_a", mul_a, 8'h00);
    check("t5_rst_mul_b", mul_b, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (150) @(negedge clk);
    clear_tx();
    send_byte(8'h02, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_tx(2, 400);
    check("t5_lo", tx_q[0], 8'h04);
    check("t5_hi", tx_q[1], 8'h00);
    repeat (10) @(negedge clk);
    clear_tx();

`ifdef UART_MUL_PARITY_EN
    // Wrong parity is a frame error; then 0x03 * 0x07 = 0x0015.
    f0 = ferr_cnt;
    bad_par = 1'b1;
    send_byte(8'h03, 1'b1);
    bad_par = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_par_ferr", ferr_cnt - f0, 1);
    check("t6_mul_a_held", mul_a, 8'h02);
    send_byte(8'h03, 1'b1);
    send_byte(8'h07, 1'b1);
    wait_tx(2, 400);
    check("t6_lo", tx_q[0], 8'h15);
    check("t6_par_lo", tx_par_q[0], 1);
    check("t6_hi", tx_q[1], 8'h00);
    check("t6_par_hi", tx_par_q[1], 0);
    repeat (10) @(negedge clk);
    clear_tx();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
